// File: rtl/pipe_alu_core.sv
// Three-stage in-order integer core: accept (S0), decode/operand read (S1), execute/writeback (S2).
// Instructions arrive on a valid/ready stream; S2 results forward into S1 so dependent ops never stall.
module pipe_alu_core #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              resume,
  output logic              halted,
  output logic              busy,
  output logic              wb_valid,
  output logic [3:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              ovf_sticky,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        fsm_state
);

  // Handshake: an instruction transfers on a rising edge where in_valid and in_ready are both 1.
  // in_ready never looks at in_valid; it drops during reset, while halted, and while a HALT drains.

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              s1_valid;
  logic [15:0]       s1_instr;
  logic              s2_valid;
  logic [3:0]        s2_op, s2_rd, s2_func;
  logic [7:0]        s2_imm;
  logic [DATA_W-1:0] s2_a, s2_b;

  logic              s2_wr, s2_ovf, fwd_ok, accept;
  logic [DATA_W-1:0] s2_result, sum, diff;
  logic [DATA_W-1:0] rf_a, rf_b, op_a, op_b;
  logic [3:0]        s1_rs1, s1_rs2;

  assign s1_rs1    = s1_instr[11:8];
  assign s1_rs2    = s1_instr[7:4];
  assign in_ready  = ~rst & ~halted & ~(s1_valid & (s1_instr[15:12] == OP_HALT))
                     & ~(s2_valid & (s2_op == OP_HALT));
  assign accept    = in_valid & in_ready;
  assign busy      = s1_valid | s2_valid;
  assign fsm_state = state;

  // Out-of-range addresses read as zero, so the read mux only spans implemented registers.
  always_comb begin
    rf_a     = '0;
    rf_b     = '0;
    dbg_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (s1_rs1 == 4'(i))   rf_a     = regs[i];
      if (s1_rs2 == 4'(i))   rf_b     = regs[i];
      if (dbg_addr == 4'(i)) dbg_data = regs[i];
    end
  end

  always_comb begin
    s2_wr     = 1'b0;
    s2_ovf    = 1'b0;
    s2_result = '0;
    sum       = s2_a + s2_b;
    diff      = s2_a - s2_b;
    if (s2_valid) begin
      case (s2_op)
        OP_ALU: begin
          s2_wr = (s2_func <= 4'd6);
          case (s2_func)
            4'd0: begin
              s2_result = sum;
              s2_ovf    = (s2_a[DATA_W-1] == s2_b[DATA_W-1]) && (sum[DATA_W-1] != s2_a[DATA_W-1]);
            end
            4'd1: begin
              s2_result = diff;
              s2_ovf    = (s2_a[DATA_W-1] != s2_b[DATA_W-1]) && (diff[DATA_W-1] != s2_a[DATA_W-1]);
            end
            4'd2:    s2_result = s2_a & s2_b;
            4'd3:    s2_result = s2_a | s2_b;
            4'd4:    s2_result = s2_a ^ s2_b;
            4'd5:    s2_result = DATA_W'($signed(s2_a) < $signed(s2_b));
            4'd6:    s2_result = s2_a << s2_b[3:0];
            default: s2_result = '0;
          endcase
        end
        OP_LDI: begin
          s2_wr     = 1'b1;
          s2_result = DATA_W'($signed(s2_imm));
        end
        default: s2_wr = 1'b0;
      endcase
    end
  end

  // A write to an unimplemented register must not leak through the bypass either.
  assign fwd_ok = s2_wr && (int'(s2_rd) < NUM_REGS);
  assign op_a   = (fwd_ok && (s2_rd == s1_rs1)) ? s2_result : rf_a;
  assign op_b   = (fwd_ok && (s2_rd == s1_rs2)) ? s2_result : rf_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_instr   <= '0;
      s2_valid   <= 1'b0;
      s2_op      <= '0;
      s2_rd      <= '0;
      s2_func    <= '0;
      s2_imm     <= '0;
      s2_a       <= '0;
      s2_b       <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      ovf_sticky <= 1'b0;
      halted     <= 1'b0;
      state      <= RUN;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_instr <= in_instr;
      s2_valid <= s1_valid;
      s2_op    <= s1_instr[15:12];
      s2_rd    <= s1_instr[11:8];
      s2_func  <= s1_instr[3:0];
      s2_imm   <= s1_instr[7:0];
      s2_a     <= op_a;
      s2_b     <= op_b;
      wb_valid <= s2_wr;
      if (s2_wr) begin
        wb_addr <= s2_rd;
        wb_data <= s2_result;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (s2_wr && (s2_rd == 4'(i))) regs[i] <= s2_result;
      end
      if (s2_ovf) ovf_sticky <= 1'b1;
      case (state)
        RUN: begin
          if (accept && (in_instr[15:12] == OP_HALT)) state <= DRAIN;
        end
        DRAIN: begin
          if (s2_valid && (s2_op == OP_HALT)) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (resume) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
